rst_err_ctrl: RTL

RST_ERR_CTRL -- requirements
Module: rst_err_ctrl

---
 rtl/rst_err_pkg.sv | 18 +
 rtl/sat_counter.sv | 20 ++
 rtl/rst_err_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/rst_err_pkg.sv
// Shared definitions for the reset/error controller: state encoding and
// default parameter values.
package rst_err_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALT    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_e;

    localparam int DEF_NUM_CH      = 1;
    localparam int DEF_RST_CYCLES  = 2;
    localparam int DEF_CNT_W       = 32;
    localparam int DEF_MAX_CYCLES  = 100000;
    localparam int DEF_HALT_ON_ERR = 1;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of
// wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rst_err_ctrl.sv
// Holds the monitored cores in reset, lets them run while counting cycles,
// and stops them on error or cycle-limit timeout until a restart pulse.
module rst_err_ctrl
    import rst_err_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int RST_CYCLES  = DEF_RST_CYCLES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int MAX_CYCLES  = DEF_MAX_CYCLES,
    parameter int HALT_ON_ERR = DEF_HALT_ON_ERR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] err,
    input  logic              restart,
    output logic              core_rst,
    output logic              halt,
    output logic              timeout,
    output logic [NUM_CH-1:0] err_latched,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  err_cycle
);

    // Hold counter only needs to reach RST_CYCLES-1 before it is cleared.
    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MAX_CYCLES - 1);

    state_e            state;
    state_e            state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              err_any;
    logic              hold_done;
    logic              stopped;
    logic              clear_logs;

    assign err_any    = |err;
    assign hold_done  = (state == ST_HOLD) && (hold_cnt == HOLD_LAST);
    assign stopped    = (state == ST_HALT) || (state == ST_TIMEOUT);
    assign clear_logs = stopped && restart;

    sat_counter #(.W(HOLD_W)) u_hold_cnt (
        .clk (clk),
        .clr (rst | hold_done),
        .en  (state == ST_HOLD),
        .cnt (hold_cnt)
    );

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk (clk),
        .clr (rst | clear_logs),
        .en  (state == ST_RUN),
        .cnt (cycle_count)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_HOLD: begin
                if (hold_done) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // An error on the final counted cycle halts rather than times out.
                if (err_any && (HALT_ON_ERR != 0)) begin
                    state_nxt = ST_HALT;
                end else if ((MAX_CYCLES != 0) && (cycle_count == CNT_LAST)) begin
                    state_nxt = ST_TIMEOUT;
                end
            end
            ST_HALT, ST_TIMEOUT: begin
                if (restart) state_nxt = ST_HOLD;
            end
            default: state_nxt = ST_HOLD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_HOLD;
            core_rst    <= 1'b1;
            halt        <= 1'b0;
            timeout     <= 1'b0;
            err_latched <= '0;
            err_cycle   <= '0;
        end else begin
            state    <= state_nxt;
            core_rst <= (state_nxt == ST_HOLD);
            halt     <= (state_nxt == ST_HALT) || (state_nxt == ST_TIMEOUT);
            timeout  <= (state_nxt == ST_TIMEOUT);
            if ((state == ST_RUN) && err_any) begin
                err_latched <= err_latched | err;
                if (err_latched == '0) err_cycle <= cycle_count;
            end else if (clear_logs) begin
                err_latched <= '0;
                err_cycle   <= '0;
            end
        end
    end

endmodule
